// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 Set-2 scan-code sequencer.
package ps2_pkg;

    // Prefix and status bytes
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_AA = 8'hAA;

    // Note key scan codes, notes 1..8
    localparam logic [7:0] SC_NOTE1 = 8'h1C;
    localparam logic [7:0] SC_NOTE2 = 8'h1B;
    localparam logic [7:0] SC_NOTE3 = 8'h23;
    localparam logic [7:0] SC_NOTE4 = 8'h2B;
    localparam logic [7:0] SC_NOTE5 = 8'h34;
    localparam logic [7:0] SC_NOTE6 = 8'h33;
    localparam logic [7:0] SC_NOTE7 = 8'h3B;
    localparam logic [7:0] SC_NOTE8 = 8'h42;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } ps2_state_t;

    // Lowest held note (1..8), or 0 when nothing is held
    function automatic logic [3:0] lowest_note(input logic [7:0] h);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (h[i]) r = 4'(i + 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Scan code to note index lookup; extended codes never map to a note.
module ps2_keymap
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [3:0] note
);

    // Pure lookup, 0 means unmapped
    always_comb begin
        note = 4'd0;
        if (!ext) begin
            case (code)
                SC_NOTE1: note = 4'd1;
                SC_NOTE2: note = 4'd2;
                SC_NOTE3: note = 4'd3;
                SC_NOTE4: note = 4'd4;
                SC_NOTE5: note = 4'd5;
                SC_NOTE6: note = 4'd6;
                SC_NOTE7: note = 4'd7;
                SC_NOTE8: note = 4'd8;
                default:  note = 4'd0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 Set-2 prefix sequencer: make/break events, held-note bitmap,
// active note selection and inter-byte timeout.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    input  logic       parity_ok,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_make,
    output logic       key_break,
    output logic [7:0] held,
    output logic [3:0] note_idx,
    output logic       note_on,
    output logic       err
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    ps2_state_t    state, nxt_state;
    logic [CW-1:0] cnt;
    logic          is_make, is_break, ev_ext;
    logic [3:0]    note;
    logic [2:0]    note_bit;
    logic [7:0]    held_nxt;
    logic [3:0]    idx_nxt;

    ps2_keymap u_keymap (
        .code (byte_data),
        .ext  (ev_ext),
        .note (note)
    );

    assign note_bit = 3'(note - 4'd1);

    // Decode the good byte against the current prefix state
    always_comb begin
        nxt_state = state;
        is_make   = 1'b0;
        is_break  = 1'b0;
        ev_ext    = (state == ST_EXT) || (state == ST_EXT_BRK);
        if (byte_valid && parity_ok) begin
            case (state)
                ST_IDLE: begin
                    if (byte_data == SC_E0)      nxt_state = ST_EXT;
                    else if (byte_data == SC_F0) nxt_state = ST_BRK;
                    else if (byte_data != SC_FA && byte_data != SC_AA) is_make = 1'b1;
                end
                ST_EXT: begin
                    if (byte_data == SC_F0) nxt_state = ST_EXT_BRK;
                    else begin
                        is_make   = 1'b1;
                        nxt_state = ST_IDLE;
                    end
                end
                default: begin
                    is_break  = 1'b1;
                    nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // Held bitmap and active-note update for the decoded event
    always_comb begin
        held_nxt = held;
        idx_nxt  = note_idx;
        if (note != 4'd0) begin
            if (is_make) begin
                held_nxt[note_bit] = 1'b1;
                // a typematic repeat keeps the current note
                if (!held[note_bit]) idx_nxt = note;
            end else if (is_break) begin
                held_nxt[note_bit] = 1'b0;
                if (note == note_idx) idx_nxt = lowest_note(held_nxt);
            end
        end
    end

    // FSM, timeout counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_code  <= 8'h00;
            key_ext   <= 1'b0;
            key_make  <= 1'b0;
            key_break <= 1'b0;
            held      <= 8'h00;
            note_idx  <= 4'd0;
            note_on   <= 1'b0;
            err       <= 1'b0;
        end else begin
            key_make  <= 1'b0;
            key_break <= 1'b0;
            err       <= 1'b0;
            held      <= held_nxt;
            note_idx  <= idx_nxt;
            note_on   <= |held_nxt;
            if (byte_valid) begin
                // a byte always wins over a coincident timeout
                cnt <= '0;
                if (!parity_ok) begin
                    err   <= 1'b1;
                    state <= ST_IDLE;
                end else begin
                    state <= nxt_state;
                    if (is_make || is_break) begin
                        key_make  <= is_make;
                        key_break <= is_break;
                        key_code  <= byte_data;
                        key_ext   <= ev_ext;
                    end
                end
            end else if (state != ST_IDLE) begin
                if (cnt == CNT_LAST) begin
                    err   <= 1'b1;
                    state <= ST_IDLE;
                    cnt   <= '0;
                end else if (cnt != '1) begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: directed bytes push expected events,
// a monitor pops and compares on every make/break/err pulse.
module tb_ps2_key_ctrl;

    localparam int TO = 16;
    localparam logic [1:0] K_MAKE = 2'd1, K_BRK = 2'd2, K_ERR = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] code;
        logic       ext;
        logic [7:0] held;
        logic [3:0] note;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       parity_ok = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_make, key_break, note_on, err;
    logic [7:0] held;
    logic [3:0] note_idx;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    ps2_key_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
        .parity_ok(parity_ok), .key_code(key_code), .key_ext(key_ext),
        .key_make(key_make), .key_break(key_break), .held(held),
        .note_idx(note_idx), .note_on(note_on), .err(err)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one byte for one cycle; optionally queue the expected response
    task automatic send(input logic [7:0] b, input logic par, input logic [1:0] kind,
                        input logic [7:0] code, input logic ext,
                        input logic [7:0] h, input logic [3:0] n);
        exp_t e;
        if (kind != 2'd0) begin
            e.kind = kind; e.code = code; e.ext = ext; e.held = h; e.note = n;
            q.push_back(e);
        end
        @(posedge clk); #1;
        byte_data = b; parity_ok = par; byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0; parity_ok = 1'b1;
    endtask

    task automatic pfx(input logic [7:0] b);
        send(b, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00, 4'd0);
    endtask

    task automatic chk_zero(input string name);
        total++;
        if ({key_code, key_ext, key_make, key_break, held, note_idx, note_on, err} != '0) begin
            bad++;
            $display("FAIL %s: code=%h ext=%b mk=%b br=%b held=%h note=%0d on=%b err=%b, want all 0",
                     name, key_code, key_ext, key_make, key_break, held, note_idx, note_on, err);
        end
    endtask

    // Monitor: every output pulse must match the oldest expected event
    initial begin
        exp_t e;
        logic [1:0] k;
        forever begin
            @(negedge clk);
            if (rst && (key_make || key_break || err)) begin
                total++;
                k = key_make ? K_MAKE : key_break ? K_BRK : K_ERR;
                if ((32'(key_make) + 32'(key_break) + 32'(err)) > 1) begin
                    bad++;
                    $display("FAIL excl: mk=%b br=%b err=%b, want one-hot", key_make, key_break, err);
                end else if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected: kind=%0d code=%h, want no event", k, key_code);
                end else begin
                    e = q.pop_front();
                    if (k != e.kind || key_code != e.code || key_ext != e.ext ||
                        held != e.held || note_idx != e.note || note_on != (|e.held)) begin
                        bad++;
                        $display("FAIL event: got kind=%0d code=%h ext=%b held=%h note=%0d on=%b, want kind=%0d code=%h ext=%b held=%h note=%0d",
                                 k, key_code, key_ext, held, note_idx, note_on,
                                 e.kind, e.code, e.ext, e.held, e.note);
                    end
                end
            end
        end
    end

    initial begin
        idle(3);
        chk_zero("reset");
        rst = 1'b1;
        idle(2);
        chk_zero("post_reset");

        // single make, then two keys and releases
        send(8'h1C, 1, K_MAKE, 8'h1C, 0, 8'h01, 4'd1);
        send(8'h23, 1, K_MAKE, 8'h23, 0, 8'h05, 4'd3);
        pfx(8'hF0);
        send(8'h23, 1, K_BRK,  8'h23, 0, 8'h01, 4'd1);
        pfx(8'hF0);
        send(8'h1C, 1, K_BRK,  8'h1C, 0, 8'h00, 4'd0);

        // extended make and break
        pfx(8'hE0);
        send(8'h75, 1, K_MAKE, 8'h75, 1, 8'h00, 4'd0);
        pfx(8'hE0); pfx(8'hF0);
        send(8'h75, 1, K_BRK,  8'h75, 1, 8'h00, 4'd0);

        // ack / BAT ignored
        pfx(8'hFA); pfx(8'hAA);

        // release of non-current key, release of key not held
        send(8'h1C, 1, K_MAKE, 8'h1C, 0, 8'h01, 4'd1);
        send(8'h42, 1, K_MAKE, 8'h42, 0, 8'h81, 4'd8);
        pfx(8'hF0);
        send(8'h1C, 1, K_BRK,  8'h1C, 0, 8'h80, 4'd8);
        pfx(8'hF0);
        send(8'h34, 1, K_BRK,  8'h34, 0, 8'h80, 4'd8);
        pfx(8'hF0);
        send(8'h42, 1, K_BRK,  8'h42, 0, 8'h00, 4'd0);

        // timeout after F0, then a make
        send(8'hF0, 1, K_ERR,  8'h42, 0, 8'h00, 4'd0);
        idle(TO + 10);
        send(8'h1C, 1, K_MAKE, 8'h1C, 0, 8'h01, 4'd1);
        pfx(8'hF0);
        send(8'h1C, 1, K_BRK,  8'h1C, 0, 8'h00, 4'd0);

        // parity error on F0, then a make
        send(8'hF0, 0, K_ERR,  8'h1C, 0, 8'h00, 4'd0);
        send(8'h1C, 1, K_MAKE, 8'h1C, 0, 8'h01, 4'd1);

        // typematic repeats, then reset mid-sequence
        send(8'h1C, 1, K_MAKE, 8'h1C, 0, 8'h01, 4'd1);
        send(8'h1C, 1, K_MAKE, 8'h1C, 0, 8'h01, 4'd1);
        pfx(8'hF0);
        rst = 1'b0;
        idle(2);
        chk_zero("mid_reset");
        rst = 1'b1;
        idle(1);
        send(8'h1C, 1, K_MAKE, 8'h1C, 0, 8'h01, 4'd1);

        idle(4);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected events never seen, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
